elevator_scheduler: RTL

Request scheduler and motion sequencer for the elevator datapath. Latches floor call buttons, chooses travel direction with a direction-preserving (SCAN) policy, and drives the floor `counter` enable/direction inputs one floor at a time. It holds the door open at each served floor. It sits between the call-button inputs and the floor `counter`, and reads the counter's `count` back as the current floor.

---
 rtl/elevator_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: latches floor calls, keeps travel direction while work lies
// ahead, steps the floor counter once per FLOOR_TICKS and holds the door at served floors.
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [3:0]            count,
  output logic                  ct_en,
  output logic                  ct_up_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TW = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'((FLOOR_TICKS > 1) ? FLOOR_TICKS - 2 : 0);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_ONE  = DW'(1);
  localparam logic PULSE_ON_ENTRY = (FLOOR_TICKS == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    dir_q;
  logic [NUM_FLOORS-1:0]   pending_q;
  logic [NUM_FLOORS-1:0]   pending_d;
  logic [TW-1:0]           tick_q;
  logic [DW-1:0]           door_q;
  logic                    ct_en_q;
  logic                    door_open_q;
  logic [3:0]              count_d;
  logic                    here_now_s;
  logic                    press_here_s;
  logic                    ahead_now_s;
  logic                    here_nxt_s;
  logic                    step_keep_s;
  logic                    step_flip_s;

  // One-hot of the given floor; floors at or beyond NUM_FLOORS map to no bit.
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [3:0] floor);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (int'(floor) == i);
    end
    return m;
  endfunction

  // Any request strictly beyond the floor in the given direction (1 = up).
  function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] req,
                                     input logic [3:0]            floor,
                                     input logic                  up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      hit = hit | (req[i] & (up ? (i > int'(floor)) : (i < int'(floor))));
    end
    return hit;
  endfunction

  // Request latch next value and the floor/request view of this and the next cycle.
  always_comb begin
    pending_d    = (pending_q | call_req) &
                   ~((state_q == S_DOOR) ? floor_mask(count) : {NUM_FLOORS{1'b0}});
    count_d      = ct_en_q ? (dir_q ? count + 4'd1 : count - 4'd1) : count;
    here_now_s   = |(pending_q & floor_mask(count));
    press_here_s = |(call_req & floor_mask(count));
    ahead_now_s  = any_ahead(pending_q, count, dir_q);
    // ct_en is a register, so a step is decided one cycle early against next-cycle state.
    here_nxt_s   = |(pending_d & floor_mask(count_d));
    step_keep_s  = !here_nxt_s && any_ahead(pending_d, count_d, dir_q);
    step_flip_s  = !here_nxt_s && any_ahead(pending_d, count_d, ~dir_q);
  end

  // Scheduler FSM with registered step, direction and door outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b1;
      pending_q   <= {NUM_FLOORS{1'b0}};
      tick_q      <= {TW{1'b0}};
      door_q      <= {DW{1'b0}};
      ct_en_q     <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          tick_q <= {TW{1'b0}};
          door_q <= {DW{1'b0}};
          if (here_now_s) begin
            state_q     <= S_DOOR;
            ct_en_q     <= 1'b0;
            door_open_q <= 1'b1;
          end else if (ahead_now_s) begin
            state_q     <= S_MOVE;
            ct_en_q     <= PULSE_ON_ENTRY & step_keep_s;
            door_open_q <= 1'b0;
          end else if (|pending_q) begin
            state_q     <= S_MOVE;
            dir_q       <= ~dir_q;
            ct_en_q     <= PULSE_ON_ENTRY & step_flip_s;
            door_open_q <= 1'b0;
          end else begin
            state_q     <= S_IDLE;
            ct_en_q     <= 1'b0;
            door_open_q <= 1'b0;
          end
        end
        S_MOVE: begin
          door_q <= {DW{1'b0}};
          if (here_now_s) begin
            state_q     <= S_DOOR;
            tick_q      <= {TW{1'b0}};
            ct_en_q     <= 1'b0;
            door_open_q <= 1'b1;
          end else if (tick_q == TICK_LAST) begin
            tick_q      <= {TW{1'b0}};
            door_open_q <= 1'b0;
            if (ct_en_q) begin
              state_q <= S_MOVE;
              ct_en_q <= PULSE_ON_ENTRY & step_keep_s;
            end else begin
              state_q <= S_IDLE;
              ct_en_q <= 1'b0;
            end
          end else begin
            state_q     <= S_MOVE;
            tick_q      <= tick_q + TICK_ONE;
            ct_en_q     <= (tick_q == TICK_PRE) & step_keep_s;
            door_open_q <= 1'b0;
          end
        end
        S_DOOR: begin
          tick_q  <= {TW{1'b0}};
          ct_en_q <= 1'b0;
          if (press_here_s) begin
            state_q     <= S_DOOR;
            door_q      <= {DW{1'b0}};
            door_open_q <= 1'b1;
          end else if (door_q == DOOR_LAST) begin
            state_q     <= S_IDLE;
            door_q      <= {DW{1'b0}};
            door_open_q <= 1'b0;
          end else begin
            state_q     <= S_DOOR;
            door_q      <= door_q + DOOR_ONE;
            door_open_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          tick_q      <= {TW{1'b0}};
          door_q      <= {DW{1'b0}};
          ct_en_q     <= 1'b0;
          door_open_q <= 1'b0;
        end
      endcase
    end
  end

  assign ct_en      = ct_en_q;
  assign ct_up_down = dir_q;
  assign door_open  = door_open_q;
  assign pending    = pending_q;

endmodule
